// File: rtl/interrupt_controller_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_controller_pkg
//   Shared definitions for the interrupt controller and its sub-blocks:
//   controller state encoding and address/source width constants.
// -----------------------------------------------------------------------------
package interrupt_controller_pkg;

    localparam int IRQ_ADDR_W  = 5;
    localparam int MAX_SOURCES = 32;

    // Controller state. DISABLED is the global-enable-clear idle state,
    // ARMED accepts requests, FIRE is the single request cycle and SERVICE
    // waits for the OS handler to re-enable interrupts.
    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARMED    = 2'd1,
        FIRE     = 2'd2,
        SERVICE  = 2'd3
    } irq_state_e;

endpackage : interrupt_controller_pkg

// File: rtl/interrupt_controller_irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
//   Combinational fixed-priority encoder. The lowest set candidate index
//   wins (bit 0 is the highest priority).
//
//   candidates  in   NUM_SOURCES  request vector
//   index       out  5            index of the winning request (0 when none)
//   valid       out  1            at least one candidate is set
// -----------------------------------------------------------------------------
module irq_priority_encoder
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SOURCES = MAX_SOURCES
) (
    input  logic [NUM_SOURCES-1:0] candidates,
    output logic [IRQ_ADDR_W-1:0]  index,
    output logic                   valid
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        index = '0;
        valid = |candidates;
        // Scan downwards so the lowest set index is the last one written.
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                index = IRQ_ADDR_W'(i);
            end
        end
    end

endmodule : irq_priority_encoder

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//   Latches rising edges of the IRQ lines into a pending register, gates them
//   with the coprocessor mask and a global enable state, and issues the
//   highest-priority request as a one-cycle interuptIn pulse with its index.
//
//   clock            in   1            system clock
//   reset            in   1            synchronous, active-low reset
//   irqLines         in   NUM_SOURCES  level IRQ lines (already synchronous)
//   interuptMask     in   32           per-source enable, 1 = allowed
//   interuptEnable   in   1            pulse: set global enable (OS return)
//   interuptDisable  in   1            pulse: clear global enable
//   cpuReady         in   1            CPU can take an interrupt this cycle
//   interuptIn       out  1            one-cycle request to the coprocessor
//   interuptAddress  out  5            index of the last issued source
//   pending          out  32           pending bits, zero-extended
//   inService        out  1            high in FIRE and SERVICE
//   globalEnable     out  1            high in ARMED
// -----------------------------------------------------------------------------
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SOURCES = MAX_SOURCES
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irqLines,
    input  logic [MAX_SOURCES-1:0] interuptMask,
    input  logic                   interuptEnable,
    input  logic                   interuptDisable,
    input  logic                   cpuReady,
    output logic                   interuptIn,
    output logic [IRQ_ADDR_W-1:0]  interuptAddress,
    output logic [MAX_SOURCES-1:0] pending,
    output logic                   inService,
    output logic                   globalEnable
);

    irq_state_e                  state_q, state_d;
    logic [NUM_SOURCES-1:0]      pending_q, pending_d;
    logic [NUM_SOURCES-1:0]      irq_prev_q, irq_prev_d;
    logic                        int_in_q, int_in_d;
    logic [IRQ_ADDR_W-1:0]       int_addr_q, int_addr_d;

    logic [NUM_SOURCES-1:0]      candidates;
    logic [NUM_SOURCES-1:0]      rise;
    logic [NUM_SOURCES-1:0]      clear_mask;
    logic [IRQ_ADDR_W-1:0]       winner;
    logic                        valid;
    logic                        fire;

    assign candidates = pending_q & interuptMask[NUM_SOURCES-1:0];

    irq_priority_encoder #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_prio (
        .candidates (candidates),
        .index      (winner),
        .valid      (valid)
    );

    // Next-state logic for the controller FSM.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        unique case (state_q)
            DISABLED: begin
                // A simultaneous disable overrides the enable.
                if (interuptEnable && !interuptDisable) state_d = ARMED;
            end
            ARMED: begin
                if (interuptDisable) begin
                    state_d = DISABLED;
                end else if (valid && cpuReady) begin
                    state_d = FIRE;
                    fire    = 1'b1;
                end
            end
            FIRE: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                // A lone disable is a no-op here; together with enable the
                // disable still wins.
                if (interuptEnable) state_d = interuptDisable ? DISABLED : ARMED;
            end
            default: state_d = DISABLED;
        endcase
    end

    // Edge capture, winner clear and request/address registers.
    always_comb begin
        rise       = irqLines & ~irq_prev_q;
        clear_mask = '0;
        if (fire) clear_mask[winner] = 1'b1;
        // A fresh edge on the line being cleared keeps its pending bit set.
        pending_d  = (pending_q & ~clear_mask) | rise;
        irq_prev_d = irqLines;
        int_in_d   = fire;
        int_addr_d = fire ? winner : int_addr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= DISABLED;
            pending_q  <= '0;
            irq_prev_q <= '0;
            int_in_q   <= 1'b0;
            int_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            irq_prev_q <= irq_prev_d;
            int_in_q   <= int_in_d;
            int_addr_q <= int_addr_d;
        end
    end

    always_comb begin
        pending                  = '0;
        pending[NUM_SOURCES-1:0] = pending_q;
    end

    assign interuptIn      = int_in_q;
    assign interuptAddress = int_addr_q;
    assign inService       = (state_q == FIRE) || (state_q == SERVICE);
    assign globalEnable    = (state_q == ARMED);

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//   Directed, table-driven bench for interrupt_controller. Each table row is
//   one clock: inputs applied before the edge, outputs compared 1 ns after.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] irqLines;
    logic [31:0] interuptMask;
    logic        interuptEnable;
    logic        interuptDisable;
    logic        cpuReady;
    logic        interuptIn;
    logic [4:0]  interuptAddress;
    logic [31:0] pending;
    logic        inService;
    logic        globalEnable;

    int n_checks = 0;
    int n_fail   = 0;

    interrupt_controller #(.NUM_SOURCES(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .irqLines        (irqLines),
        .interuptMask    (interuptMask),
        .interuptEnable  (interuptEnable),
        .interuptDisable (interuptDisable),
        .cpuReady        (cpuReady),
        .interuptIn      (interuptIn),
        .interuptAddress (interuptAddress),
        .pending         (pending),
        .inService       (inService),
        .globalEnable    (globalEnable)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [31:0] irq;
        logic [31:0] mask;
        logic        en;
        logic        dis;
        logic        rdy;
        logic        e_in;
        logic [4:0]  e_addr;
        logic [31:0] e_pend;
        logic        e_svc;
        logic        e_ge;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    task automatic add(input logic rst, input logic [31:0] irq, input logic [31:0] mask,
                       input logic en, input logic dis, input logic rdy,
                       input logic e_in, input logic [4:0] e_addr, input logic [31:0] e_pend,
                       input logic e_svc, input logic e_ge);
        vec_t v;
        v.rst = rst; v.irq = irq; v.mask = mask; v.en = en; v.dis = dis; v.rdy = rdy;
        v.e_in = e_in; v.e_addr = e_addr; v.e_pend = e_pend; v.e_svc = e_svc; v.e_ge = e_ge;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] irq, input logic [31:0] mask,
                         input logic en, input logic dis, input logic rdy);
        reset = rst; irqLines = irq; interuptMask = mask;
        interuptEnable = en; interuptDisable = dis; cpuReady = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, ALL, ALL, 1'b0, 1'b0, 1'b0);

        //   rst irq           mask          en dis rdy | in addr pend          svc ge
        // Reset with all lines high, then release and enable.
        add(0, ALL,          ALL,          0, 0, 0,     0, 0, 32'h0,          0, 0);
        add(0, ALL,          ALL,          0, 0, 0,     0, 0, 32'h0,          0, 0);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 0, 32'h0,          0, 0);
        add(1, 32'h0,        ALL,          1, 0, 0,     0, 0, 32'h0,          0, 1);
        // Single IRQ on line 5; held line must not re-fire.
        add(1, 32'h20,       ALL,          0, 0, 1,     0, 0, 32'h20,         0, 1);
        add(1, 32'h20,       ALL,          0, 0, 1,     1, 5, 32'h0,          1, 0);
        add(1, 32'h20,       ALL,          0, 0, 1,     0, 5, 32'h0,          1, 0);
        add(1, 32'h20,       ALL,          1, 0, 1,     0, 5, 32'h0,          0, 1);
        add(1, 32'h20,       ALL,          0, 0, 1,     0, 5, 32'h0,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 1,     0, 5, 32'h0,          0, 1);
        // Priority and mask: lines 3 and 9, line 3 masked.
        add(1, 32'h208,      32'hFFFFFFF7, 0, 0, 1,     0, 5, 32'h208,        0, 1);
        add(1, 32'h0,        32'hFFFFFFF7, 0, 0, 1,     1, 9, 32'h8,          1, 0);
        add(1, 32'h0,        32'hFFFFFFF7, 0, 0, 1,     0, 9, 32'h8,          1, 0);
        add(1, 32'h0,        ALL,          1, 0, 1,     0, 9, 32'h8,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 1,     1, 3, 32'h0,          1, 0);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 3, 32'h0,          1, 0);
        add(1, 32'h0,        ALL,          1, 0, 0,     0, 3, 32'h0,          0, 1);
        // Gating by cpuReady for 4 cycles.
        add(1, 32'h4,        ALL,          0, 0, 0,     0, 3, 32'h4,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 3, 32'h4,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 3, 32'h4,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 3, 32'h4,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 3, 32'h4,          0, 1);
        add(1, 32'h0,        ALL,          0, 0, 1,     1, 2, 32'h0,          1, 0);
        add(1, 32'h0,        ALL,          0, 0, 1,     0, 2, 32'h0,          1, 0);
        // Disable is ignored in SERVICE.
        add(1, 32'h0,        ALL,          0, 1, 1,     0, 2, 32'h0,          1, 0);
        add(1, 32'h0,        ALL,          1, 0, 1,     0, 2, 32'h0,          0, 1);
        // Disabled: capture continues, no request.
        add(1, 32'h4,        ALL,          0, 1, 1,     0, 2, 32'h4,          0, 0);
        add(1, 32'h4,        ALL,          0, 0, 1,     0, 2, 32'h4,          0, 0);
        add(1, 32'h4,        ALL,          0, 0, 1,     0, 2, 32'h4,          0, 0);
        // Disable collides with a fire opportunity.
        add(1, 32'h4,        ALL,          1, 0, 1,     0, 2, 32'h4,          0, 1);
        add(1, 32'h4,        ALL,          0, 1, 1,     0, 2, 32'h4,          0, 0);
        // Enable+disable together from DISABLED.
        add(1, 32'h4,        ALL,          1, 1, 1,     0, 2, 32'h4,          0, 0);
        add(1, 32'h4,        ALL,          1, 0, 0,     0, 2, 32'h4,          0, 1);
        add(1, 32'h4,        ALL,          0, 0, 1,     1, 2, 32'h0,          1, 0);
        add(1, 32'h4,        ALL,          0, 0, 1,     0, 2, 32'h0,          1, 0);
        // Enable+disable together from SERVICE.
        add(1, 32'h4,        ALL,          1, 1, 1,     0, 2, 32'h0,          0, 0);
        add(1, 32'h4,        ALL,          1, 0, 0,     0, 2, 32'h0,          0, 1);
        // New edge on line 4 in the same cycle its bit is cleared.
        add(1, 32'h10,       ALL,          0, 0, 0,     0, 2, 32'h10,         0, 1);
        add(1, 32'h0,        ALL,          0, 0, 0,     0, 2, 32'h10,         0, 1);
        add(1, 32'h10,       ALL,          0, 0, 1,     1, 4, 32'h10,         1, 0);
        add(1, 32'h10,       ALL,          0, 0, 0,     0, 4, 32'h10,         1, 0);
        // Reset during FIRE with pending 0x12 left behind.
        add(1, 32'h10,       ALL,          1, 0, 0,     0, 4, 32'h10,         0, 1);
        add(1, 32'h32,       ALL,          0, 0, 0,     0, 4, 32'h32,         0, 1);
        add(1, 32'h32,       32'hFFFFFFED, 0, 0, 1,     1, 5, 32'h12,         1, 0);
        add(0, 32'h0,        32'hFFFFFFED, 0, 0, 1,     0, 0, 32'h0,          0, 0);
        add(1, 32'h0,        ALL,          0, 0, 1,     0, 0, 32'h0,          0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].irq, vecs[i].mask, vecs[i].en, vecs[i].dis, vecs[i].rdy);
            tick();
            check($sformatf("v%0d.interuptIn", i),      32'(interuptIn),      32'(vecs[i].e_in));
            check($sformatf("v%0d.interuptAddress", i), 32'(interuptAddress), 32'(vecs[i].e_addr));
            check($sformatf("v%0d.pending", i),         pending,              vecs[i].e_pend);
            check($sformatf("v%0d.inService", i),       32'(inService),       32'(vecs[i].e_svc));
            check($sformatf("v%0d.globalEnable", i),    32'(globalEnable),    32'(vecs[i].e_ge));
        end

        // Masked line 7 stays pending, then fires once unmasked.
        drive(1'b1, 32'h80, 32'hFFFFFF7F, 1'b1, 1'b0, 1'b1);
        tick();
        check("mask.pend", pending, 32'h80);
        check("mask.armed", 32'(globalEnable), 32'd1);
        interuptEnable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mask.hold%0d.in", i), 32'(interuptIn), 32'd0);
            check($sformatf("mask.hold%0d.pend", i), pending, 32'h80);
        end
        interuptMask = ALL;
        tick();
        check("unmask.in", 32'(interuptIn), 32'd1);
        check("unmask.addr", 32'(interuptAddress), 32'd7);
        check("unmask.pend", pending, 32'h0);
        tick();
        check("unmask.pulse_end", 32'(interuptIn), 32'd0);
        check("unmask.service", 32'(inService), 32'd1);

        // Hold-off: a new edge on line 6 during SERVICE waits for enable.
        irqLines = 32'hC0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("holdoff%0d.in", i), 32'(interuptIn), 32'd0);
        end
        check("holdoff.pend", pending, 32'h40);
        interuptEnable = 1'b1;
        tick();
        interuptEnable = 1'b0;
        begin
            int  budget;
            bit  seen;
            budget = 0;
            seen   = 1'b0;
            while (!seen && budget < 10) begin
                tick();
                budget++;
                if (interuptIn === 1'b1) seen = 1'b1;
            end
            check("holdoff.fired", 32'(seen), 32'd1);
            check("holdoff.latency", 32'(budget), 32'd1);
            check("holdoff.addr", 32'(interuptAddress), 32'd6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_interrupt_controller
